// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath front end: default sizes, frame
// selectors, loader state encoding and a vector-unpacking helper.
package neuron_pkg;

  localparam int DEF_N_IN   = 32;
  localparam int DEF_DATA_W = 16;

  localparam logic SEL_DENDRITE = 1'b0;
  localparam logic SEL_WEIGHT   = 1'b1;

  // Widest flat vector elem() accepts; callers zero-extend into it.
  localparam int ELEM_VEC_W = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FILL_D,
    FILL_W,
    COMMIT_D,
    COMMIT_W
  } state_t;

  function automatic logic [DEF_DATA_W-1:0] elem(input logic [ELEM_VEC_W-1:0] vec,
                                                 input int i);
    return vec[i*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/neuron_input_loader.sv
// Serial word stream -> parallel dendrite/weight frames for the neuron.
// Dendrites are double-buffered; weight frames commit atomically.
module neuron_input_loader
  import neuron_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_en,
  input  logic                     in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_IN*DATA_W-1:0]   out_dendrites,
  output logic [(N_IN+1)*DATA_W-1:0] out_weights,
  output logic [N_IN-1:0]          out_enabled,
  output logic                     weights_ok,
  output logic                     busy
);

  localparam int IW = $clog2(N_IN + 2);
  localparam logic [IW-1:0] LAST_D = IW'(N_IN - 1);
  localparam logic [IW-1:0] LAST_W = IW'(N_IN);

  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must lie in [0, DATA_W)");
  end

  state_t state, state_nxt;
  logic [IW-1:0] idx;

  logic [N_IN-1:0][DATA_W-1:0] work_d, out_d;
  logic [N_IN:0][DATA_W-1:0]   work_w, out_w;
  logic [N_IN-1:0]             work_en, out_en;
  logic                        ov, wok;

  logic free, accept, wr_d, wr_w, commit_d, commit_w;

  assign free   = !ov || out_ready;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_d      = 1'b0;
    wr_w      = 1'b0;
    commit_d  = 1'b0;
    commit_w  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_sel == SEL_WEIGHT) begin
            wr_w      = 1'b1;
            state_nxt = FILL_W;
          end else begin
            wr_d      = 1'b1;
            state_nxt = (N_IN == 1) ? COMMIT_D : FILL_D;
          end
        end
      end
      FILL_D: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_d = 1'b1;
          if (idx == LAST_D) state_nxt = COMMIT_D;
        end
      end
      FILL_W: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_w = 1'b1;
          if (idx == LAST_W) state_nxt = COMMIT_W;
        end
      end
      COMMIT_D: begin
        if (free) begin
          commit_d  = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT_W: begin
        if (free) begin
          commit_w  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (commit_d || commit_w) idx <= '0;
      else if (accept)          idx <= idx + 1'b1;
    end
  end

  // Working buffers: idx selects the slot for the word being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_d  <= '0;
      work_en <= '0;
      work_w  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_d && idx == IW'(i)) begin
          work_d[i]  <= in_data;
          work_en[i] <= in_en;
        end
      end
      for (int i = 0; i <= N_IN; i++) begin
        if (wr_w && idx == IW'(i)) work_w[i] <= in_data;
      end
    end
  end

  // A dendrite commit that coincides with out_ready keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_d  <= '0;
      out_en <= '0;
      out_w  <= '0;
      ov     <= 1'b0;
      wok    <= 1'b0;
    end else begin
      if (commit_d) begin
        out_d  <= work_d;
        out_en <= work_en;
      end
      if (commit_w) begin
        out_w <= work_w;
        wok   <= 1'b1;
      end
      if (commit_d)             ov <= 1'b1;
      else if (ov && out_ready) ov <= 1'b0;
    end
  end

  assign out_dendrites = out_d;
  assign out_enabled   = out_en;
  assign out_weights   = out_w;
  assign out_valid     = ov;
  assign weights_ok    = wok;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_neuron_input_loader.sv
// Self-checking bench: directed frames with literal expectations plus random
// traffic, compared every cycle against a frame-level queue model.
module tb_neuron_input_loader;
  import neuron_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_en, in_sel;
  logic [W-1:0]     in_data;
  logic             out_valid, out_ready, weights_ok, busy;
  logic [N*W-1:0]   out_dendrites;
  logic [(N+1)*W-1:0] out_weights;
  logic [N-1:0]     out_enabled;

  neuron_input_loader #(.N_IN(N), .DATA_W(W), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_en(in_en), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dendrites(out_dendrites), .out_weights(out_weights),
    .out_enabled(out_enabled), .weights_ok(weights_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ed(input int i);
    return elem(ELEM_VEC_W'(out_dendrites), i);
  endfunction

  function automatic logic [W-1:0] ewt(input int i);
    return elem(ELEM_VEC_W'(out_weights), i);
  endfunction

  // Frame-level model: a fill buffer that, once full, waits for a free output.
  logic [W-1:0] m_d [N];
  logic         m_en[N];
  logic [W-1:0] m_w [N+1];
  logic [W-1:0] f_d [N+1];
  logic         f_en[N];
  int           f_n;
  bit           f_wt, m_ov, m_wok;

  function automatic int flen(input bit wt);
    return wt ? N + 1 : N;
  endfunction

  function automatic bit frame_full();
    return f_n != 0 && f_n == flen(f_wt);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_d[i] = '0; m_en[i] = 1'b0; f_en[i] = 1'b0; end
      for (int i = 0; i <= N; i++) begin m_w[i] = '0; f_d[i] = '0; end
      f_n = 0; f_wt = 1'b0; m_ov = 1'b0; m_wok = 1'b0;
    end else if (frame_full()) begin
      if (!m_ov || out_ready) begin
        if (f_wt) begin
          for (int i = 0; i <= N; i++) m_w[i] = f_d[i];
          m_wok = 1'b1;
          m_ov  = 1'b0;
        end else begin
          for (int i = 0; i < N; i++) begin m_d[i] = f_d[i]; m_en[i] = f_en[i]; end
          m_ov = 1'b1;
        end
        f_n = 0;
      end
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (in_valid) begin
        if (f_n == 0) f_wt = in_sel;
        f_d[f_n] = in_data;
        if (f_n < N) f_en[f_n] = in_en;
        f_n++;
      end
    end
  end

  logic [N*W-1:0]     x_d;
  logic [(N+1)*W-1:0] x_w;
  logic [N-1:0]       x_en;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin x_d[i*W +: W] = m_d[i]; x_en[i] = m_en[i]; end
    for (int i = 0; i <= N; i++) x_w[i*W +: W] = m_w[i];
    cmp("out_valid", 256'(out_valid), 256'(m_ov));
    cmp("weights_ok", 256'(weights_ok), 256'(m_wok));
    cmp("out_dendrites", 256'(out_dendrites), 256'(x_d));
    cmp("out_enabled", 256'(out_enabled), 256'(x_en));
    cmp("out_weights", 256'(out_weights), 256'(x_w));
    cmp("busy", 256'(busy), 256'(f_n != 0));
    if (!rst) cmp("in_ready", 256'(in_ready), 256'(!frame_full()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns one step after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic e, input logic s);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_en = e; in_sel = s;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low exp=accept_within_50");
    end
  endtask

  logic [W-1:0] wv [N+1];
  logic [W-1:0] nw [N+1];

  initial begin
    wv[0] = 16'h0100; wv[1] = 16'h0200; wv[2] = 16'hFF00; wv[3] = 16'h0080; wv[4] = 16'h0010;
    nw[0] = 16'h0300; nw[1] = 16'h0400; nw[2] = 16'h0500; nw[3] = 16'h0600; nw[4] = 16'h0700;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_en = 1'b0; in_sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    cmp("rst_out_valid", 256'(out_valid), 256'(0));
    cmp("rst_weights_ok", 256'(weights_ok), 256'(0));
    cmp("rst_busy", 256'(busy), 256'(0));
    cmp("rst_in_ready", 256'(in_ready), 256'(1));
    cmp("rst_out_weights", 256'(out_weights), 256'(0));
    tick();

    // Weight frame, no stall: committed one cycle after the bias word.
    for (int i = 0; i <= N; i++) send(wv[i], 1'b0, SEL_WEIGHT);
    in_valid = 1'b0;
    cmp("w_ok_before_commit", 256'(weights_ok), 256'(0));
    tick();
    cmp("w_ok_after", 256'(weights_ok), 256'(1));
    for (int i = 0; i <= N; i++) cmp("w_elem", 256'(ewt(i)), 256'(wv[i]));
    cmp("w_out_valid", 256'(out_valid), 256'(0));

    // Dendrite frame with downstream ready.
    out_ready = 1'b1;
    send(16'h0001, 1'b1, SEL_DENDRITE);
    send(16'h0002, 1'b0, SEL_DENDRITE);
    send(16'h0003, 1'b1, SEL_DENDRITE);
    send(16'h0004, 1'b1, SEL_DENDRITE);
    in_valid = 1'b0;
    cmp("d_valid_k", 256'(out_valid), 256'(0));
    tick();
    cmp("d_valid_k1", 256'(out_valid), 256'(1));
    cmp("d_enabled", 256'(out_enabled), 256'(4'b1101));
    cmp("d_elem2", 256'(ed(2)), 256'(16'h0003));
    tick();
    cmp("d_consumed", 256'(out_valid), 256'(0));

    // Two frames back to back while the output is blocked.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(16'h0011 + 16'(i), 1'b1, SEL_DENDRITE);
    for (int i = 0; i < N; i++) send(16'h0021 + 16'(i), 1'b0, SEL_DENDRITE);
    in_valid = 1'b0;
    tick(); tick();
    cmp("bb_in_ready", 256'(in_ready), 256'(0));
    cmp("bb_busy", 256'(busy), 256'(1));
    cmp("bb_first", 256'(ed(0)), 256'(16'h0011));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmp("bb_no_gap", 256'(out_valid), 256'(1));
    cmp("bb_second", 256'(ed(0)), 256'(16'h0021));
    cmp("bb_enabled", 256'(out_enabled), 256'(4'b0000));

    // Weight frame under a presented, unconsumed dendrite frame.
    for (int i = 0; i <= N; i++) send(nw[i], 1'b0, SEL_WEIGHT);
    in_valid = 1'b0;
    tick();
    cmp("wh_in_ready", 256'(in_ready), 256'(0));
    cmp("wh_old_w", 256'(ewt(0)), 256'(16'h0100));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmp("wh_valid", 256'(out_valid), 256'(0));
    cmp("wh_new_w", 256'(ewt(4)), 256'(16'h0700));
    cmp("wh_ok", 256'(weights_ok), 256'(1));

    // Asynchronous reset in the middle of a frame.
    send(16'h0031, 1'b1, SEL_DENDRITE);
    send(16'h0032, 1'b1, SEL_DENDRITE);
    send(16'h0033, 1'b1, SEL_DENDRITE);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    cmp("ar_weights", 256'(out_weights), 256'(0));
    cmp("ar_ok", 256'(weights_ok), 256'(0));
    cmp("ar_busy", 256'(busy), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(16'h0041 + 16'(i), 1'b1, SEL_DENDRITE);
    in_valid = 1'b0;
    tick();
    cmp("ar_valid", 256'(out_valid), 256'(1));
    cmp("ar_elem0", 256'(ed(0)), 256'(16'h0041));
    cmp("ar_elem3", 256'(ed(3)), 256'(16'h0044));
    cmp("ar_enabled", 256'(out_enabled), 256'(4'hF));
    tick();

    // in_sel after word 0 must not change the frame type.
    send(16'h0051, 1'b1, SEL_DENDRITE);
    send(16'h0052, 1'b1, SEL_WEIGHT);
    send(16'h0053, 1'b0, SEL_DENDRITE);
    send(16'h0054, 1'b1, SEL_WEIGHT);
    in_valid = 1'b0;
    tick();
    cmp("sel_valid", 256'(out_valid), 256'(1));
    cmp("sel_elem1", 256'(ed(1)), 256'(16'h0052));
    cmp("sel_no_w", 256'(weights_ok), 256'(0));
    cmp("sel_busy", 256'(busy), 256'(0));

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_en     = 1'($urandom);
      in_sel    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
